hall_decoder: RTL
=================

Name: hall_decoder

Overview:
- Feedback-side companion to the BLDC commutation/gate-drive logic.
- Samples the three raw Hall sensor lines and synchronises and deglitches them.
- Checks that each new Hall state is a legal step in the commutation sequence and tracks direction and signed electrical position.
- Measures the step period for the speed loop and flags stall and sequence errors; presents a clean Hall state to the commutation logic.

Parameters:
FILT_LEN, 4, consecutive cycles a new synchronised value must hold before acceptance (>=1)
PERIOD_W, 24, width of the step-period timer and period output
POS_W, 16, width of the signed position counter
STALL_CYCLES, 2000000, timer value at which stall is declared (must be < 2^PERIOD_W)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
hall_in  in  3  raw Hall lines {H2,H1,H0}, asynchronous to clk
clr_pos  in  1  synchronous clear of pos
hall_q  out  3  filtered Hall state
hall_valid  out  1  hall_q is a legal state (not 0, not 7) and a reference is held
dir  out  1  direction of last step: 1 forward, 0 reverse
step  out  1  one-cycle pulse per legal step
pos  out  POS_W  signed step count, two's-complement wrap
period  out  PERIOD_W  clk cycles between the last two same-direction steps
period_valid  out  1  period is meaningful
stall  out  1  no legal step for STALL_CYCLES
seq_err  out  1  one-cycle pulse on illegal state or illegal transition
err_cnt  out  8  saturating count of seq_err pulses

Behaviour:
- Reset (async, rst_n=0):
  - sync flops, hall_q, pos, period, err_cnt = 0
  - hall_valid, dir, step, period_valid, seq_err = 0
  - stall = 1
  - FSM = INIT
- Synchroniser: two flops on hall_in. Synchronised value settles one edge after the first flop captures.
- Filter:
  - Counter runs while the sync value differs from hall_q and the sync value is unchanged; any sync change restarts it.
  - After FILT_LEN consecutive equal cycles, hall_q takes the sync value.
  - A change held stable from edge k therefore appears on hall_q at edge k+1+FILT_LEN.
  - Pulses shorter than FILT_LEN cycles never reach hall_q.
- Event: hall_q changes. Event processing is registered. step, dir, pos, seq_err and err_cnt update one cycle after the hall_q change.
- Forward sequence (dir=1): 1->3->2->6->4->5->1. Reverse is the inverse.
- FSM INIT:
  - Event to a legal state: take it as reference, set hall_valid=1, go to TRACK. No step is issued and the period timer is cleared.
  - Event to 0 or 7: seq_err pulse and err_cnt+1; stay in INIT.
- FSM TRACK, on each event:
  - Forward successor: step=1, dir=1, pos+1.
  - Reverse predecessor: step=1, dir=0, pos-1.
  - New state 0 or 7: seq_err pulse, err_cnt+1, hall_valid=0, period_valid=0; go to INIT.
  - Any other legal state (skipped position): seq_err pulse, err_cnt+1, no pos change, period_valid=0, timer cleared. New state becomes the reference; stay in TRACK.
- Period timer:
  - Increments every cycle in TRACK and saturates at all-ones.
  - On a step: timer restarts so the cycle after the step reads 1.
  - On a step whose previous event was a same-direction step: period <= timer value + 1 (cycles between the two step pulses) and period_valid=1.
  - On a direction reversal: period=0, period_valid=0.
  - On the first step after INIT or after a skip: period_valid stays 0.
- Stall:
  - When timer == STALL_CYCLES: stall=1, period=0, period_valid=0.
  - stall clears on the next step.
  - stall stays 1 throughout INIT.
- pos:
  - Wraps two's complement.
  - clr_pos sets pos=0 and has priority over a coincident step. dir and period still update on that step.
- err_cnt saturates at 255.
- Reset mid-sequence returns everything to its reset values. After release, the first legal filtered state is a reference only.

Test Plan:
Use FILT_LEN=4, STALL_CYCLES=1000 for all scenarios.
- Forward run:
  - Stimulus: hall 1,3,2,6,4,5,1, each held 100 cycles.
  - Response: hall_q lags hall_in by 6 cycles. 6 step pulses, pos=6, dir=1.
  - Response: period=100 with period_valid=1 from the 2nd step. seq_err never pulses.
- Reverse and reversal:
  - Stimulus: from 1, apply 5,4, then 5, each held 100 cycles.
  - Response: pos=-2, dir=0, period=100 after the 2nd reverse step.
  - Response: on 5, dir=1, pos=-1, period_valid=0.
- Glitch rejection:
  - Stimulus: hold 3, pulse hall_in to 2 for 3 cycles.
  - Response: hall_q stays 3, no step, no seq_err. A 4-cycle-stable pulse is accepted.
- Illegal state:
  - Stimulus: in TRACK apply 7, then 3.
  - Response: seq_err pulse, err_cnt=1, hall_valid=0. 3 becomes the reference with no step and hall_valid=1.
- Skip:
  - Stimulus: 1 then 2.
  - Response: seq_err pulse, pos unchanged, period_valid=0. The next 6 gives a forward step.
- Stall and clear:
  - Stimulus: hold one state more than 1000 cycles after a step.
  - Response: stall=1, period=0. The next step clears stall.
  - Stimulus: assert clr_pos on the same cycle as a step pulse.
  - Response: pos=0.

Source files
------------

// File: rtl/hall_decoder.sv
// rtl/hall_decoder.sv - Hall sensor synchroniser, deglitch filter, sequence tracker and speed timer
module hall_decoder #(
  parameter int FILT_LEN     = 4,
  parameter int PERIOD_W     = 24,
  parameter int POS_W        = 16,
  parameter int STALL_CYCLES = 2000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          hall_in,
  input  logic                clr_pos,
  output logic [2:0]          hall_q,
  output logic                hall_valid,
  output logic                dir,
  output logic                step,
  output logic [POS_W-1:0]    pos,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stall,
  output logic                seq_err,
  output logic [7:0]          err_cnt
);

  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);
  localparam logic [CW:0]         FL      = (CW+1)'(FILT_LEN);
  localparam logic [PERIOD_W-1:0] STALL_T = PERIOD_W'(STALL_CYCLES);
  localparam logic [PERIOD_W-1:0] T_MAX   = '1;

  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  logic [2:0]          sync1, sync2;
  logic [2:0]          cand;
  logic [CW-1:0]       fcnt;
  logic [CW:0]         fnext;
  logic [2:0]          hall_prev;
  logic [0:0]          state;
  logic [PERIOD_W-1:0] timer;
  logic                last_step;

  logic ev, legal_new, is_fwd, is_rev;
  logic step_f, step_r, err, to_track, to_init, skip, step_any;

  // Forward commutation order 1->3->2->6->4->5->1; illegal codes map to 0.
  function automatic logic [2:0] fwd_next(input logic [2:0] s);
    case (s)
      3'd1:    fwd_next = 3'd3;
      3'd3:    fwd_next = 3'd2;
      3'd2:    fwd_next = 3'd6;
      3'd6:    fwd_next = 3'd4;
      3'd4:    fwd_next = 3'd5;
      3'd5:    fwd_next = 3'd1;
      default: fwd_next = 3'd0;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous Hall lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 3'd0;
      sync2 <= 3'd0;
    end else begin
      sync1 <= hall_in;
      sync2 <= sync1;
    end
  end

  // Run length of the current candidate, counting this cycle.
  always_comb begin
    fnext = (CW+1)'(1);
    if (sync2 == cand) fnext = {1'b0, fcnt} + (CW+1)'(1);
  end

  // Deglitch: accept a new value once it has been stable for FILT_LEN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_q <= 3'd0;
      cand   <= 3'd0;
      fcnt   <= '0;
    end else if (sync2 == hall_q) begin
      fcnt <= '0;
    end else if (fnext >= FL) begin
      hall_q <= sync2;
      fcnt   <= '0;
    end else begin
      cand <= sync2;
      fcnt <= fnext[CW-1:0];
    end
  end

  assign ev        = (hall_q != hall_prev);
  assign legal_new = (hall_q != 3'd0) && (hall_q != 3'd7);
  assign is_fwd    = (hall_q == fwd_next(hall_prev));
  assign is_rev    = (hall_prev == fwd_next(hall_q));
  assign step_any  = step_f | step_r;

  // Classify each filtered-state change against the reference.
  always_comb begin
    step_f   = 1'b0;
    step_r   = 1'b0;
    err      = 1'b0;
    to_track = 1'b0;
    to_init  = 1'b0;
    skip     = 1'b0;
    if (ev) begin
      if (state == INIT) begin
        if (legal_new) to_track = 1'b1;
        else           err      = 1'b1;
      end else if (!legal_new) begin
        err     = 1'b1;
        to_init = 1'b1;
      end else if (is_fwd) begin
        step_f = 1'b1;
      end else if (is_rev) begin
        step_r = 1'b1;
      end else begin
        err  = 1'b1;
        skip = 1'b1;
      end
    end
  end

  // Reference tracking state and validity of the filtered state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      hall_prev  <= 3'd0;
      hall_valid <= 1'b0;
    end else begin
      hall_prev <= hall_q;
      if (to_track) begin
        state      <= TRACK;
        hall_valid <= 1'b1;
      end else if (to_init) begin
        state      <= INIT;
        hall_valid <= 1'b0;
      end
    end
  end

  // Step pulse, direction and signed position; clear beats a coincident step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= 1'b0;
      dir  <= 1'b0;
      pos  <= '0;
    end else begin
      step <= step_any;
      if (step_any) dir <= step_f;
      if (clr_pos)     pos <= '0;
      else if (step_f) pos <= pos + POS_W'(1);
      else if (step_r) pos <= pos - POS_W'(1);
    end
  end

  // Sequence error pulse and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      seq_err <= err;
      if (err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Step-period timer, period measurement and stall detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stall        <= 1'b1;
      last_step    <= 1'b0;
    end else if (to_init) begin
      timer        <= '0;
      period_valid <= 1'b0;
      stall        <= 1'b1;
      last_step    <= 1'b0;
    end else if (state == INIT) begin
      timer     <= '0;
      last_step <= 1'b0;
    end else begin
      if (step_any) begin
        timer     <= '0;
        stall     <= 1'b0;
        last_step <= 1'b1;
        if (last_step && (dir == step_f)) begin
          period       <= (timer == T_MAX) ? timer : timer + PERIOD_W'(1);
          period_valid <= 1'b1;
        end else if (last_step) begin
          period       <= '0;
          period_valid <= 1'b0;
        end
      end else if (skip) begin
        timer        <= '0;
        period_valid <= 1'b0;
        last_step    <= 1'b0;
      end else if (timer != T_MAX) begin
        timer <= timer + PERIOD_W'(1);
      end
      if (!step_any && (timer == STALL_T)) begin
        stall        <= 1'b1;
        period       <= '0;
        period_valid <= 1'b0;
      end
    end
  end

endmodule
